// File: rtl/adpcm_addb_if.sv
// ADDB datapath bundle: quantized difference and signal estimate in,
// reconstructed signal out. The master drives DQ/SE; the slave (ADDB) returns SR.
`timescale 1ns/1ps

interface adpcm_addb_if;
  logic [15:0] DQ;  // sign-magnitude: bit15 sign, bits14:0 magnitude
  logic [14:0] SE;  // two's complement signal estimate
  logic [15:0] SR;  // two's complement reconstructed signal

  modport master (output DQ, output SE, input SR);
  modport slave  (input DQ, input SE, output SR);
endinterface

// File: rtl/adpcm_addb.sv
// G.726 ADDB: SR = DQ + SE with 16-bit wrap-around, purely combinational.
// Clock, reset and scan ports exist only so the scan-insertion wrapper has
// something to stitch; none of them touch the SR path.
`timescale 1ns/1ps

module adpcm_addb (
  input  logic           clk,
  input  logic           reset,
  input  logic           scan_in0,
  input  logic           scan_in1,
  input  logic           scan_in2,
  input  logic           scan_in3,
  input  logic           scan_in4,
  input  logic           scan_enable,
  input  logic           test_mode,
  output logic           scan_out0,
  output logic           scan_out1,
  output logic           scan_out2,
  output logic           scan_out3,
  output logic           scan_out4,
  adpcm_addb_if.slave    bus
);

  logic        dqs;
  logic [14:0] dq_mag;
  logic [15:0] dqi;
  logic        ses;
  logic [15:0] sei;
  logic [15:0] sr_sum;

  // DQ sign-magnitude -> two's complement. Negating a zero magnitude gives
  // zero, so negative zero (0x8000) collapses to 0x0000 without a special case.
  always_comb begin
    dqs    = bus.DQ[15];
    dq_mag = bus.DQ[14:0];
    if (dqs) dqi = 16'h0000 - {1'b0, dq_mag};
    else     dqi = {1'b0, dq_mag};
  end

  // SE sign-extension from 15 to 16 bits.
  always_comb begin
    ses = bus.SE[14];
    sei = {ses, bus.SE};
  end

  // Modulo-2^16 add; carry out is discarded on purpose (no saturation), which
  // matches the reference arithmetic bit-for-bit.
  always_comb begin
    sr_sum = dqi + sei;
  end

  assign bus.SR = sr_sum;

  // Scan outputs are placeholders until the chain is stitched in.
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // Ports kept only for the scan wrapper; folded here so they stay visible
  // but intentionally drive nothing.
  logic unused_scan_ports;
  assign unused_scan_ports = ^{clk, reset, scan_in0, scan_in1, scan_in2,
                               scan_in3, scan_in4, scan_enable, test_mode};

endmodule

// File: tb/tb_adpcm_addb.sv
// Bench for adpcm_addb: directed vectors with hand-computed SR, a signed
// integer model checked on every negedge, reset/scan independence checks.
`timescale 1ns/1ps

module tb_adpcm_addb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scan_in0 = 1'b0, scan_in1 = 1'b0, scan_in2 = 1'b0, scan_in3 = 1'b0, scan_in4 = 1'b0;
  logic scan_enable = 1'b0;
  logic test_mode = 1'b0;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  adpcm_addb_if bus();

  adpcm_addb dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .bus(bus)
  );

  always #10 clk = ~clk;

  // Signed-integer view of the arithmetic: DQ as +/- magnitude, SE as a
  // 15-bit signed value, sum reduced modulo 65536.
  function automatic logic [15:0] model(input logic [15:0] dq, input logic [14:0] se);
    int d, s, r;
    d = dq[15] ? -int'(dq[14:0]) : int'(dq[14:0]);
    s = se[14] ? int'(se) - 32768 : int'(se);
    r = (d + s) % 65536;
    if (r < 0) r = r + 65536;
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Continuous model compare on every negedge once stimulus is live.
  always @(negedge clk) begin
    if (cmp_en) chk("model", bus.SR, model(bus.DQ, bus.SE));
  end

  // Apply after posedge, check DUT and model against the literal at negedge.
  task automatic apply(input string name, input logic [15:0] dq, input logic [14:0] se,
                       input logic [15:0] exp);
    @(posedge clk);
    #1;
    bus.DQ = dq;
    bus.SE = se;
    @(negedge clk);
    chk(name, bus.SR, exp);
    chk({name, "_mdl"}, model(dq, se), exp);
  endtask

  typedef struct { logic [15:0] dq; logic [14:0] se; logic [15:0] sr; } vec_t;
  vec_t vecs[$];

  initial begin
    bus.DQ = 16'h0000;
    bus.SE = 15'h0000;

    // Reset asserted: SR still purely combinational, scan outs tied low.
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sr", bus.SR, 16'h0000);
    chk("rst_scan", {11'd0, scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    apply("basic",     16'h0005, 15'h0003, 16'h0008);
    apply("neg_dq",    16'h8005, 15'h0003, 16'hFFFE);
    apply("neg_se",    16'h0000, 15'h7FFF, 16'hFFFF);
    apply("negzero",   16'h8000, 15'h0000, 16'h0000);
    apply("negzero_s", 16'h8000, 15'h4000, 16'hC000);
    apply("wrap_pos",  16'h7FFF, 15'h3FFF, 16'hBFFE);
    apply("wrap_neg",  16'hFFFF, 15'h4000, 16'h4001);

    // Reference-style vector set, hand-computed.
    vecs.push_back('{16'h0100, 15'h7F00, 16'h0000});  // 256 + (-256)
    vecs.push_back('{16'h80FF, 15'h00FF, 16'h0000});  // -255 + 255
    vecs.push_back('{16'h1234, 15'h0123, 16'h1357});
    vecs.push_back('{16'h8001, 15'h4000, 16'hBFFF});  // -1 + -16384
    vecs.push_back('{16'h7FFF, 15'h4000, 16'h3FFF});  // 32767 - 16384
    vecs.push_back('{16'h0000, 15'h3FFF, 16'h3FFF});
    vecs.push_back('{16'h8010, 15'h0020, 16'h0010});  // -16 + 32
    vecs.push_back('{16'h0040, 15'h7FC0, 16'h0000});  // 64 + (-64)
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].dq, vecs[i].se, vecs[i].sr);

    // Walking-ones sweep on both operands, checked by the model process.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      bus.DQ = 16'h0001 << i;
      bus.SE = 15'h7FFF >> (i % 15);
    end

    // Reset pulse mid-cycle with functional-mode noise: SR must not move.
    @(posedge clk);
    #1;
    bus.DQ = 16'h0010;
    bus.SE = 15'h0020;
    #4 reset = 1'b0;
    scan_enable = 1'b1;
    test_mode = 1'b1;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b10101;
    #1 chk("rst_mid", bus.SR, 16'h0030);
    chk("scan_mid", {11'd0, scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 16'h0000);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_after", bus.SR, 16'h0030);
    scan_enable = 1'b0;
    test_mode = 1'b0;

    @(posedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adpcm_addb.md
Name: adpcm_addb

Overview:
- G.726 ADPCM ADDB block: reconstructs the signal SR = DQ + SE.
- Inputs: quantized difference signal DQ (sign-magnitude) and signal estimate SE (two's complement).
- Sits between IQUAN/reconstruction and the adaptive predictor in both encoder and decoder.
- Purely combinational datapath. Clock, reset and scan ports exist only for the team's standard scan-insertion wrapper.

Parameters:
- none (widths fixed by G.726: DQ 16, SE 15, SR 16)

Ports:
- reset  input  1  asynchronous active-low reset; no effect on the combinational SR path
- clk  input  1  single clock; unused by datapath, present for scan
- scan_in0..scan_in4  input  1 each  scan chain inputs
- scan_enable  input  1  scan shift enable
- test_mode  input  1  scan test mode
- DQ  input  16  quantized difference; bit15 = sign, bits14:0 = magnitude
- SE  input  15  signal estimate, two's complement
- scan_out0..scan_out4  output  1 each  scan chain outputs; tied 0 in RTL, driven after scan insertion
- SR  output  16  reconstructed signal, two's complement

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- SR is combinational from DQ and SE with zero cycles of latency. SR must be valid within half a clock period (10 ns at 20 ns clk) of an input change.
- No registers in the datapath, so SR has no reset value. SR follows inputs regardless of reset, clk, scan_enable or test_mode in functional mode.
- DQ conversion:
  - DQS = DQ[15].
  - If DQS = 0: DQI = DQ.
  - If DQS = 1: DQI = (65536 − DQ[14:0]) mod 65536, i.e. the 16-bit two's-complement negation of the magnitude.
  - Negative zero (DQ = 0x8000) yields DQI = 0x0000.
- SE conversion:
  - SES = SE[14].
  - SEI = SE sign-extended to 16 bits, i.e. SE + 0x8000 when SES = 1, else SE.
- SR = (DQI + SEI) mod 65536.
- 16-bit wrap-around on overflow; no saturation. This matches the G.726 reference exactly, bit-for-bit.
- All 2^16 × 2^15 input combinations are legal; no X propagation from unused ports.
- Scan outputs drive 0 pre-insertion.

Test Plan:
- DQ=0x0005, SE=0x0003 -> SR=0x0008 at the following negedge.
- DQ=0x8005 (−5), SE=0x0003 -> SR=0xFFFE. DQ=0x0000, SE=0x7FFF (−1) -> SR=0xFFFF.
- Negative zero: DQ=0x8000, SE=0x0000 -> SR=0x0000. DQ=0x8000, SE=0x4000 -> SR=0xC000.
- Wrap-around, positive: DQ=0x7FFF, SE=0x3FFF -> SR=0xBFFE. Wrap-around, negative: DQ=0xFFFF, SE=0x4000 -> SR=0x4001.
- Reset independence: hold DQ=0x0010, SE=0x0020 and pulse reset low mid-cycle -> SR stays 0x0030 throughout. Scan outputs read 0.
- Vector regression: replay G.726 reference dq/se/sr vector sets (rates 40/32/24/16, A/µ-law, enc/dec, reset/homing, normal/overload/I). Apply each input after posedge and compare SR at the next negedge; zero mismatches required.
